// File: rtl/n2_arf_key_loader_if.sv
// Bundle between the AES key loader and its surroundings: command channel,
// key-word stream, ARF read snoop and the registered ARF write port.
interface n2_arf_key_loader_if #(
    parameter int unsigned AW = 4
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_base;
    logic [5:0]    cmd_nwords;
    logic          kw_valid;
    logic          kw_ready;
    logic [31:0]   kw_data;
    logic [AW-1:0] rd_addr;
    logic          rd_enable;
    logic [AW-1:0] wr_addr;
    logic [63:0]   wr_data;
    logic [1:0]    wr_enable;
    logic          busy;
    logic          done;
    logic          err;

    // Loader side
    modport slave (
        input  cmd_valid, cmd_base, cmd_nwords, kw_valid, kw_data, rd_addr, rd_enable,
        output cmd_ready, kw_ready, wr_addr, wr_data, wr_enable, busy, done, err
    );

    // Command issuer / ARF side
    modport master (
        output cmd_valid, cmd_base, cmd_nwords, kw_valid, kw_data, rd_addr, rd_enable,
        input  cmd_ready, kw_ready, wr_addr, wr_data, wr_enable, busy, done, err
    );
endinterface

// File: rtl/n2_arf_key_loader.sv
// Write-side sequencer for the SPU AES key register file. Packs pairs of
// 32b expanded-key words into 64b half-entry writes and holds a write for as
// long as the ARF is reading the same entry in that cycle.
module n2_arf_key_loader #(
    parameter int unsigned ENTRIES   = 16,
    parameter int unsigned AW        = 4,
    parameter int unsigned MAX_WORDS = 60
) (
    input logic                  l2clk,
    input logic                  reset,
    n2_arf_key_loader_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

    state_t        state_q;
    logic [AW-1:0] base_q;
    logic [5:0]    nwords_q;
    logic [5:0]    k_q;        // words accepted so far
    logic [4:0]    pair_q;     // half-writes issued so far (= k_pair/2)
    logic [31:0]   buf0_q;
    logic [31:0]   buf1_q;
    logic [AW-1:0] wr_addr_q;
    logic [63:0]   wr_data_q;
    logic [1:0]    wr_en_q;
    logic          done_q;
    logic          err_q;

    logic [AW-1:0] tgt_d;
    logic          conflict_d;
    logic          cmd_bad_d;

    // Target entry of the pending pair and same-cycle read collision
    always_comb begin
        tgt_d      = AW'((32'(base_q) + 32'(pair_q[4:1])) % ENTRIES);
        conflict_d = bus.rd_enable && (bus.rd_addr == tgt_d);
        cmd_bad_d  = (bus.cmd_nwords == 6'd0) || (32'(bus.cmd_nwords) > MAX_WORDS);
    end

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.kw_ready  = (state_q == COLLECT);
    assign bus.busy      = (state_q != IDLE);
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.wr_enable = wr_en_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;

    // Command/word sequencing FSM with registered ARF write port and pulses
    always_ff @(posedge l2clk) begin
        if (reset) begin
            state_q   <= IDLE;
            base_q    <= '0;
            nwords_q  <= '0;
            k_q       <= '0;
            pair_q    <= '0;
            buf0_q    <= '0;
            buf1_q    <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_en_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.cmd_valid) begin
                        if (cmd_bad_d) begin
                            err_q <= 1'b1;
                        end else begin
                            base_q   <= bus.cmd_base;
                            nwords_q <= bus.cmd_nwords;
                            k_q      <= '0;
                            pair_q   <= '0;
                            state_q  <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.kw_valid) begin
                        // An even word clears the upper slot so an odd final word packs as {0, word}
                        if (!k_q[0]) begin
                            buf0_q <= bus.kw_data;
                            buf1_q <= '0;
                        end else begin
                            buf1_q <= bus.kw_data;
                        end
                        k_q <= k_q + 6'd1;
                        if (k_q[0] || ((k_q + 6'd1) == nwords_q)) begin
                            state_q <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (!conflict_d) begin
                        wr_addr_q <= tgt_d;
                        wr_data_q <= {buf1_q, buf0_q};
                        wr_en_q   <= pair_q[0] ? 2'b10 : 2'b01;
                        pair_q    <= pair_q + 5'd1;
                        state_q   <= (k_q == nwords_q) ? DONE : COLLECT;
                    end
                end
                DONE: begin
                    done_q  <= 1'b1;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_n2_arf_key_loader.sv
// Directed bench for n2_arf_key_loader: a table of load commands with
// hand-computed write traces, plus hand sequences for read conflicts and
// reset in the middle of a load.
module tb_n2_arf_key_loader;
    logic l2clk = 1'b0;
    logic reset = 1'b1;

    n2_arf_key_loader_if #(.AW(4)) bus ();

    n2_arf_key_loader #(.ENTRIES(16), .AW(4), .MAX_WORDS(60)) dut (
        .l2clk (l2clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 l2clk = ~l2clk;

    int errors = 0;
    int checks = 0;

    // Write trace and pulse counters gathered on the falling edge
    logic [3:0]  log_addr[$];
    logic [1:0]  log_en[$];
    logic [63:0] log_data[$];
    int done_cnt = 0;
    int err_cnt  = 0;
    int bad_en   = 0;
    bit busy_seen = 1'b0;

    always @(negedge l2clk) begin
        if (bus.wr_enable != 2'b00) begin
            log_addr.push_back(bus.wr_addr);
            log_en.push_back(bus.wr_enable);
            log_data.push_back(bus.wr_data);
        end
        if (bus.wr_enable == 2'b11) bad_en++;
        if (bus.done) done_cnt++;
        if (bus.err) err_cnt++;
        if (bus.busy) busy_seen = 1'b1;
    end

    function automatic logic [31:0] word(input int v, input int i);
        logic [7:0]  vb;
        logic [15:0] ib;
        vb = v[7:0];
        ib = i[15:0];
        return {vb, 8'h5A, ib};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_en.delete();
        log_data.delete();
        done_cnt  = 0;
        err_cnt   = 0;
        busy_seen = 1'b0;
    endtask

    task automatic issue_cmd(input int base, input int n);
        int waited;
        bus.cmd_base   = base[3:0];
        bus.cmd_nwords = n[5:0];
        bus.cmd_valid  = 1'b1;
        waited = 0;
        forever begin
            @(negedge l2clk);
            if (bus.cmd_ready) break;
            waited++;
            if (waited > 20) begin
                chk("cmd_ready_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge l2clk);
        #1 bus.cmd_valid = 1'b0;
    endtask

    task automatic send_words(input int v, input int cnt);
        int waited;
        for (int i = 0; i < cnt; i++) begin
            bus.kw_valid = 1'b1;
            bus.kw_data  = word(v, i);
            waited = 0;
            forever begin
                @(negedge l2clk);
                if (bus.kw_ready) break;
                waited++;
                if (waited > 20) break;
            end
            if (waited > 20) begin
                chk("kw_ready_timeout", 64'd0, 64'd1);
                bus.kw_valid = 1'b0;
                return;
            end
            @(posedge l2clk);
            #1;
        end
        bus.kw_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        forever begin
            @(negedge l2clk);
            if (!bus.busy) break;
            waited++;
            if (waited > 300) begin
                chk("busy_timeout", 64'd0, 64'd1);
                break;
            end
        end
        repeat (2) @(negedge l2clk);
        @(posedge l2clk);
        #1;
    endtask

    typedef struct {
        int base; int n; int nw;
        int fa;   int fe;              // first write: entry, enable
        int la;   int le;              // last write: entry, enable
        int hi;   int lo;              // last write data word indices (hi<0 -> zero)
        int e;                         // err expected
    } vec_t;

    vec_t vec[9];
    int   wrap_addr[6];

    initial begin
        logic [63:0] exp_data;
        logic [31:0] hi_w;
        int li;

        bus.cmd_valid  = 1'b0;
        bus.cmd_base   = '0;
        bus.cmd_nwords = '0;
        bus.kw_valid   = 1'b0;
        bus.kw_data    = '0;
        bus.rd_addr    = '0;
        bus.rd_enable  = 1'b0;

        vec[0] = '{0,  4,  2, 0,  1, 0,  2, 3,  2,  0};
        vec[1] = '{14, 12, 6, 14, 1, 0,  2, 11, 10, 0};
        vec[2] = '{5,  5,  3, 5,  1, 6,  1, -1, 4,  0};
        vec[3] = '{2,  0,  0, 0,  0, 0,  0, 0,  0,  1};
        vec[4] = '{2,  61, 0, 0,  0, 0,  0, 0,  0,  1};
        vec[5] = '{9,  1,  1, 9,  1, 9,  1, -1, 0,  0};
        vec[6] = '{15, 60, 30, 15, 1, 13, 2, 59, 58, 0};
        vec[7] = '{0,  63, 0, 0,  0, 0,  0, 0,  0,  1};
        vec[8] = '{1,  6,  3, 1,  1, 2,  1, 5,  4,  0};
        wrap_addr = '{14, 14, 15, 15, 0, 0};

        repeat (3) @(posedge l2clk);
        #1 reset = 1'b0;
        @(negedge l2clk);
        chk("rst_wr_enable", 64'(bus.wr_enable), 64'd0);
        chk("rst_wr_addr",   64'(bus.wr_addr),   64'd0);
        chk("rst_wr_data",   bus.wr_data,        64'd0);
        chk("rst_busy",      64'(bus.busy),      64'd0);
        chk("rst_done",      64'(bus.done),      64'd0);
        chk("rst_err",       64'(bus.err),       64'd0);
        chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
        @(posedge l2clk);
        #1;

        for (int v = 0; v < 9; v++) begin
            clear_log();
            issue_cmd(vec[v].base, vec[v].n);
            if (vec[v].e == 0) send_words(v, vec[v].n);
            wait_idle();
            chk($sformatf("v%0d_err_cnt", v),  64'(err_cnt),  64'(vec[v].e));
            chk($sformatf("v%0d_done_cnt", v), 64'(done_cnt), 64'(1 - vec[v].e));
            chk($sformatf("v%0d_writes", v),   64'(log_en.size()), 64'(vec[v].nw));
            chk($sformatf("v%0d_busy_seen", v), 64'(busy_seen), 64'(1 - vec[v].e));
            if (log_en.size() > 0 && vec[v].nw > 0) begin
                li = log_en.size() - 1;
                hi_w = (vec[v].hi < 0) ? 32'h0 : word(v, vec[v].hi);
                exp_data = {hi_w, word(v, vec[v].lo)};
                chk($sformatf("v%0d_first_addr", v), 64'(log_addr[0]), 64'(vec[v].fa));
                chk($sformatf("v%0d_first_en", v),   64'(log_en[0]),   64'(vec[v].fe));
                chk($sformatf("v%0d_first_data", v), log_data[0], {word(v, 1 < vec[v].n ? 1 : 0) & {32{vec[v].n > 1}}, word(v, 0)});
                chk($sformatf("v%0d_last_addr", v),  64'(log_addr[li]), 64'(vec[v].la));
                chk($sformatf("v%0d_last_en", v),    64'(log_en[li]),    64'(vec[v].le));
                chk($sformatf("v%0d_last_data", v),  log_data[li], exp_data);
            end
            if (v == 1 && log_addr.size() == 6) begin
                for (int j = 0; j < 6; j++)
                    chk($sformatf("wrap_addr%0d", j), 64'(log_addr[j]), 64'(wrap_addr[j]));
            end
        end

        // Read of the target entry for three cycles stalls the pending write
        clear_log();
        issue_cmd(3, 2);
        send_words(20, 2);
        bus.rd_enable = 1'b1;
        bus.rd_addr   = 4'd3;
        for (int c = 0; c < 3; c++) begin
            @(negedge l2clk);
            chk($sformatf("stall_c%0d_wr_en", c), 64'(bus.wr_enable), 64'd0);
            chk($sformatf("stall_c%0d_busy", c),  64'(bus.busy),      64'd1);
            @(posedge l2clk);
            #1;
        end
        bus.rd_enable = 1'b0;
        @(negedge l2clk);
        chk("stall_release_wr_en", 64'(bus.wr_enable), 64'd0);
        @(negedge l2clk);
        chk("stall_pulse_wr_en", 64'(bus.wr_enable), 64'd1);
        chk("stall_pulse_addr",  64'(bus.wr_addr),   64'd3);
        chk("stall_pulse_data",  bus.wr_data, {word(20, 1), word(20, 0)});
        @(posedge l2clk);
        #1;
        wait_idle();
        chk("stall_writes", 64'(log_en.size()), 64'd1);
        chk("stall_done",   64'(done_cnt),       64'd1);

        // Read of a different entry does not delay the write
        clear_log();
        issue_cmd(3, 2);
        send_words(21, 2);
        bus.rd_enable = 1'b1;
        bus.rd_addr   = 4'd5;
        @(negedge l2clk);
        chk("nostall_wr_en0", 64'(bus.wr_enable), 64'd0);
        @(posedge l2clk);
        #1;
        @(negedge l2clk);
        chk("nostall_wr_en1", 64'(bus.wr_enable), 64'd1);
        chk("nostall_addr",   64'(bus.wr_addr),   64'd3);
        bus.rd_enable = 1'b0;
        @(posedge l2clk);
        #1;
        wait_idle();
        chk("nostall_done", 64'(done_cnt), 64'd1);

        // Reset after three of eight words abandons the load
        clear_log();
        issue_cmd(0, 8);
        send_words(22, 3);
        reset = 1'b1;
        @(posedge l2clk);
        #1 reset = 1'b0;
        @(negedge l2clk);
        chk("midrst_wr_en",   64'(bus.wr_enable), 64'd0);
        chk("midrst_busy",    64'(bus.busy),      64'd0);
        chk("midrst_wr_addr", 64'(bus.wr_addr),   64'd0);
        chk("midrst_wr_data", bus.wr_data,        64'd0);
        chk("midrst_ready",   64'(bus.cmd_ready), 64'd1);
        repeat (3) @(negedge l2clk);
        chk("midrst_done_cnt", 64'(done_cnt), 64'd0);
        chk("midrst_err_cnt",  64'(err_cnt),  64'd0);
        chk("midrst_writes",   64'(log_en.size()), 64'd1);
        @(posedge l2clk);
        #1;
        clear_log();
        issue_cmd(7, 2);
        send_words(23, 2);
        wait_idle();
        chk("postrst_writes", 64'(log_en.size()), 64'd1);
        if (log_en.size() > 0) begin
            chk("postrst_addr", 64'(log_addr[0]), 64'd7);
            chk("postrst_en",   64'(log_en[0]),   64'd1);
            chk("postrst_data", log_data[0], {word(23, 1), word(23, 0)});
        end
        chk("postrst_done", 64'(done_cnt), 64'd1);

        chk("never_both_halves", 64'(bad_en), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule
